// File: rtl/noc_pkg.sv
// Shared NoC definitions: port/VC geometry, flit layout and flit type codes.
package noc_pkg;

   localparam int unsigned PORT_N   = 5;
   localparam int unsigned PORT_W   = 3;
   localparam int unsigned VCH_N    = 4;
   localparam int unsigned VCH_W    = 2;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned TYPE_MSB = 31;
   localparam int unsigned TYPE_LSB = 29;
   localparam int unsigned TYPE_W   = TYPE_MSB - TYPE_LSB + 1;

   localparam logic [TYPE_W-1:0] TYPE_NONE     = TYPE_W'(0);
   localparam logic [TYPE_W-1:0] TYPE_HEAD     = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] TYPE_BODY     = TYPE_W'(2);
   localparam logic [TYPE_W-1:0] TYPE_TAIL     = TYPE_W'(3);
   localparam logic [TYPE_W-1:0] TYPE_HEADTAIL = TYPE_W'(4);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              valid;
      logic [VCH_W-1:0]  vch;
   } router_i_t;

endpackage

// File: rtl/output_port_pkg.sv
// Output-port additions: default credit depth and the per-VC status bundle.
package output_port_pkg;

   import noc_pkg::*;

   localparam int unsigned CREDIT_N_DEFAULT = 4;
   localparam int unsigned CREDIT_W         = $clog2(CREDIT_N_DEFAULT + 1);

   typedef struct packed {
      logic [VCH_N-1:0] rdy;
      logic [VCH_N-1:0] lck;
   } outputc_wire_o_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way one-hot arbiter.
//   OUTPUT_PORT_RR_EN defined  : round robin, search starts after the last winner.
//   OUTPUT_PORT_RR_EN undefined: fixed priority, lowest index wins, no state.
// Ports: clk, rst_n, req_i[N] requests, upd_i pointer update enable,
//        gnt_o[N] one-hot grant (zero when no request).
module rr_arbiter #(
   parameter int unsigned N = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         upd_i,
   output logic [N-1:0] gnt_o
);

   localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

`ifdef OUTPUT_PORT_RR_EN
   logic [W-1:0] ptr_q;
   logic [W-1:0] idx;
   logic [W-1:0] gidx;
   logic         found;

   // Scan ptr+1 .. ptr+N (mod N); first requester wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      gidx  = ptr_q;
      for (int i = 1; i <= N; i++) begin
         idx = W'((32'(ptr_q) + 32'(i)) % N);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            gidx       = idx;
            found      = 1'b1;
         end
      end
   end

   // Pointer remembers the last granted requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (upd_i && found)
         ptr_q <= gidx;
   end
`else
   logic unused_ok;
   assign unused_ok = clk ^ rst_n ^ upd_i;

   // Walk from the top down so the lowest requester is the last write.
   always_comb begin
      gnt_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i])
            gnt_o = N'(1) << i;
      end
   end
`endif

endmodule

// File: rtl/output_port.sv
// Router output channel: arbitrates input-port requests, keeps per-VC wormhole
// locks and downstream credits, and registers one flit per cycle onto the link.
// Arbitration policy selected by OUTPUT_PORT_RR_EN (round robin when defined,
// fixed lowest-index priority otherwise).
// Ports: clk, rst_n; req_i/vch_i/flit_i per-input requests; grt_o one-hot grant
// (combinational); rdy_o credit>0 per VC; lck_o lock per VC; ack_i credit
// returns; outputc_o registered link flit.
module output_port
   import noc_pkg::*;
   import output_port_pkg::*;
#(
   parameter int unsigned ROUTERID = 0,
   parameter int unsigned PCHID    = 0,
   parameter int unsigned CREDIT_N = CREDIT_N_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PORT_N-1:0]             req_i,
   input  logic [PORT_N-1:0][VCH_W-1:0]  vch_i,
   input  router_i_t [PORT_N-1:0]        flit_i,
   output logic [PORT_N-1:0]             grt_o,
   output logic [VCH_N-1:0]              rdy_o,
   output logic [VCH_N-1:0]              lck_o,
   input  logic [VCH_N-1:0]              ack_i,
   output router_i_t                     outputc_o
);

   localparam int unsigned      CNT_W   = $clog2(CREDIT_N + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_N);

   logic [VCH_N-1:0][CNT_W-1:0]   credit_q, credit_d;
   logic [VCH_N-1:0]              lock_q, lock_d;
   logic [VCH_N-1:0][PORT_W-1:0]  owner_q, owner_d;
   outputc_wire_o_t               wire_q, wire_d;
   router_i_t                     link_d;

   logic [PORT_N-1:0][TYPE_W-1:0] ftype;
   logic [PORT_N-1:0]             elig;
   logic [PORT_N-1:0]             grt;
   logic [PORT_W-1:0]             gidx;
   logic                          gvld;
   logic [VCH_W-1:0]              gvch;
   logic [TYPE_W-1:0]             gtype;

   logic unused_ok;
   assign unused_ok = ^{flit_i, 32'(ROUTERID), 32'(PCHID)};

   // Eligibility: valid request, credit on the target VC, and either a packet
   // start on a free VC or a continuation from the VC's current owner.
   always_comb begin
      ftype = '0;
      elig  = '0;
      for (int p = 0; p < PORT_N; p++) begin
         ftype[p] = flit_i[p].data[TYPE_MSB:TYPE_LSB];
         if (req_i[p] && flit_i[p].valid && (credit_q[vch_i[p]] != '0)) begin
            if (!lock_q[vch_i[p]])
               elig[p] = (ftype[p] == TYPE_HEAD) || (ftype[p] == TYPE_HEADTAIL);
            else
               elig[p] = (owner_q[vch_i[p]] == PORT_W'(p)) &&
                         ((ftype[p] == TYPE_BODY) || (ftype[p] == TYPE_TAIL));
         end
      end
   end

   rr_arbiter #(
      .N(PORT_N)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (elig),
      .upd_i (gvld),
      .gnt_o (grt)
   );

   assign grt_o = grt;

   // One-hot grant to index.
   always_comb begin
      gidx = '0;
      for (int p = 0; p < PORT_N; p++) begin
         if (grt[p])
            gidx = PORT_W'(p);
      end
   end

   assign gvld  = |grt;
   assign gvch  = vch_i[gidx];
   assign gtype = ftype[gidx];

   // Next state for credits, locks, owners, link register and status.
   always_comb begin
      credit_d = credit_q;
      lock_d   = lock_q;
      owner_d  = owner_q;
      link_d   = '0;
      wire_d   = '0;

      for (int v = 0; v < VCH_N; v++) begin
         if (gvld && (gvch == VCH_W'(v)) && !ack_i[v])
            credit_d[v] = credit_q[v] - CNT_W'(1);
         else if (!(gvld && (gvch == VCH_W'(v))) && ack_i[v] && (credit_q[v] != CNT_MAX))
            credit_d[v] = credit_q[v] + CNT_W'(1);
      end

      if (gvld) begin
         link_d.data  = flit_i[gidx].data;
         link_d.valid = 1'b1;
         link_d.vch   = gvch;
         if (gtype == TYPE_HEAD) begin
            lock_d[gvch]  = 1'b1;
            owner_d[gvch] = gidx;
         end else if (gtype == TYPE_TAIL) begin
            lock_d[gvch] = 1'b0;
         end
      end

      for (int v = 0; v < VCH_N; v++)
         wire_d.rdy[v] = (credit_d[v] != '0);
      wire_d.lck = lock_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q   <= {VCH_N{CNT_MAX}};
         lock_q     <= '0;
         owner_q    <= '0;
         outputc_o  <= '0;
         wire_q.rdy <= '1;
         wire_q.lck <= '0;
      end else begin
         credit_q  <= credit_d;
         lock_q    <= lock_d;
         owner_q   <= owner_d;
         outputc_o <= link_d;
         wire_q    <= wire_d;
      end
   end

   assign rdy_o = wire_q.rdy;
   assign lck_o = wire_q.lck;

endmodule

// File: tb/tb_output_port.sv
// Bench for output_port: directed stimulus, link flits checked by a scoreboard
// monitor; grants and VC status checked directly. Honors OUTPUT_PORT_RR_EN.
module tb_output_port;
   import noc_pkg::*;

   logic                         clk;
   logic                         rst_n;
   logic [PORT_N-1:0]            req_i;
   logic [PORT_N-1:0][VCH_W-1:0] vch_i;
   router_i_t [PORT_N-1:0]       flit_i;
   logic [PORT_N-1:0]            grt_o;
   logic [VCH_N-1:0]             rdy_o;
   logic [VCH_N-1:0]             lck_o;
   logic [VCH_N-1:0]             ack_i;
   router_i_t                    outputc_o;

   int unsigned cyc;
   int          checks;
   int          errors;
   int          order [4];

   typedef struct packed {
      logic [31:0]       cyc;
      logic [DATA_W-1:0] data;
      logic [VCH_W-1:0]  vch;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   output_port #(
      .ROUTERID (0),
      .PCHID    (1),
      .CREDIT_N (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .vch_i     (vch_i),
      .flit_i    (flit_i),
      .grt_o     (grt_o),
      .rdy_o     (rdy_o),
      .lck_o     (lck_o),
      .ack_i     (ack_i),
      .outputc_o (outputc_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every valid link flit must match the head of the scoreboard.
   always @(negedge clk) begin
      if (outputc_o.valid) begin
         if (sb.size() == 0) begin
            chk("link_unexpected", 64'(outputc_o), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("link_cyc", 64'(cyc), 64'(e.cyc));
            chk("link_data", 64'(outputc_o.data), 64'(e.data));
            chk("link_vch", 64'(outputc_o.vch), 64'(e.vch));
         end
      end else begin
         chk("link_idle_zero", 64'(outputc_o), 64'(0));
      end
   end

   task automatic clr();
      req_i  = '0;
      vch_i  = '0;
      flit_i = '0;
      ack_i  = '0;
   endtask

   task automatic put(input int p, input int v, input logic [TYPE_W-1:0] t, input int pay);
      req_i[p]        = 1'b1;
      vch_i[p]        = VCH_W'(v);
      flit_i[p].valid = 1'b1;
      flit_i[p].vch   = VCH_W'(v);
      flit_i[p].data  = {t, (DATA_W - TYPE_W)'(pay)};
   endtask

   // Expect port p's current flit on the link next cycle.
   task automatic expf(input int p);
      sb.push_back(exp_t'({32'(cyc + 1), flit_i[p].data, vch_i[p]}));
   endtask

   // Check the combinational grant, then advance one cycle and clear inputs.
   task automatic tick(input logic [PORT_N-1:0] g, input string nm);
      @(negedge clk);
      chk(nm, 64'(grt_o), 64'(g));
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic acks(input int v, input int n);
      for (int i = 0; i < n; i++) begin
         ack_i[v] = 1'b1;
         tick('0, "ack_no_grant");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
`ifdef OUTPUT_PORT_RR_EN
      order = '{0, 2, 3, 0};
`else
      order = '{0, 0, 0, 0};
`endif
      checks = 0;
      errors = 0;
      clr();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grt", 64'(grt_o), 64'(0));
      chk("rst_rdy", 64'(rdy_o), 64'(4'b1111));
      chk("rst_lck", 64'(lck_o), 64'(4'b0000));
      chk("rst_link", 64'(outputc_o), 64'(0));
      rst_n = 1'b1;

      // Type NONE never granted; single HEADTAIL port0 -> VC0.
      put(0, 0, TYPE_NONE, 5);
      tick(5'b00000, "none_no_grant");
      put(0, 0, TYPE_HEADTAIL, 1);
      expf(0);
      tick(5'b00001, "ht_grant");
      chk("ht_lck", 64'(lck_o), 64'(4'b0000));
      chk("ht_rdy", 64'(rdy_o), 64'(4'b1111));
      tick('0, "idle");
      acks(0, 1);

      // Wormhole on VC1: port1 HEAD/BODY/TAIL, port2 HEAD waits.
      put(1, 1, TYPE_HEAD, 10); put(2, 1, TYPE_HEAD, 20); expf(1);
      tick(5'b00010, "wh_head");
      chk("lck_after_head", 64'(lck_o), 64'(4'b0010));
      put(1, 1, TYPE_BODY, 11); put(2, 1, TYPE_HEAD, 20); expf(1);
      tick(5'b00010, "wh_body");
      put(1, 1, TYPE_TAIL, 12); put(2, 1, TYPE_HEAD, 20); expf(1);
      tick(5'b00010, "wh_tail");
      chk("lck_after_tail", 64'(lck_o), 64'(4'b0000));
      put(2, 1, TYPE_HEAD, 20); expf(2);
      tick(5'b00100, "wh_second_head");
      chk("vc1_lck_p2", 64'(lck_o), 64'(4'b0010));
      chk("vc1_rdy_empty", 64'(rdy_o), 64'(4'b1101));
      put(2, 1, TYPE_TAIL, 21); ack_i[1] = 1'b1;
      tick(5'b00000, "no_bypass_vc1");
      put(2, 1, TYPE_TAIL, 21); ack_i[1] = 1'b1; expf(2);
      tick(5'b00100, "tail_with_ack");
      chk("vc1_lck_free", 64'(lck_o), 64'(4'b0000));
      chk("vc1_rdy_back", 64'(rdy_o), 64'(4'b1111));
      acks(1, 3);

      // Credit exhaustion on VC0.
      for (int i = 0; i < 4; i++) begin
         put(0, 0, TYPE_HEADTAIL, 30 + i); expf(0);
         tick(5'b00001, "exh_send");
      end
      chk("rdy_exhausted", 64'(rdy_o), 64'(4'b1110));
      put(0, 0, TYPE_HEADTAIL, 34);
      tick(5'b00000, "exh_stall");
      put(0, 0, TYPE_HEADTAIL, 34); ack_i[0] = 1'b1;
      tick(5'b00000, "exh_ack_no_bypass");
      put(0, 0, TYPE_HEADTAIL, 34); expf(0);
      tick(5'b00001, "exh_after_ack");

      // Send and ack together at credit 2 leaves credit at 2.
      acks(0, 2);
      put(0, 0, TYPE_HEADTAIL, 40); ack_i[0] = 1'b1; expf(0);
      tick(5'b00001, "send_ack_same");
      put(0, 0, TYPE_HEADTAIL, 41); expf(0);
      tick(5'b00001, "credit2_send1");
      put(0, 0, TYPE_HEADTAIL, 42); expf(0);
      tick(5'b00001, "credit2_send2");
      put(0, 0, TYPE_HEADTAIL, 43);
      tick(5'b00000, "credit2_held");
      chk("rdy_after_credit2", 64'(rdy_o), 64'(4'b1110));

      // Ack at full credit saturates.
      acks(0, 5);
      for (int i = 0; i < 4; i++) begin
         put(0, 0, TYPE_HEADTAIL, 50 + i); expf(0);
         tick(5'b00001, "sat_send");
      end
      put(0, 0, TYPE_HEADTAIL, 54);
      tick(5'b00000, "sat_stall");
      acks(0, 4);

      // Arbitration among ports 0, 2, 3 after a port-4 grant.
      put(4, 1, TYPE_HEADTAIL, 60); expf(4);
      tick(5'b10000, "p4_grant");
      for (int k = 0; k < 4; k++) begin
         put(0, 0, TYPE_HEADTAIL, 70);
         put(2, 2, TYPE_HEADTAIL, 72);
         put(3, 3, TYPE_HEADTAIL, 73);
         expf(order[k]);
         tick(PORT_N'(1) << order[k], "arb_grant");
      end
      tick('0, "idle");

      // Reset while VC0 is locked with one credit left.
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      put(0, 0, TYPE_HEAD, 80); expf(0);
      tick(5'b00001, "rst_head");
      put(0, 0, TYPE_BODY, 81); expf(0);
      tick(5'b00001, "rst_body1");
      put(0, 0, TYPE_BODY, 82);
      tick(5'b00001, "rst_body2");
      chk("pre_rst_valid", 64'(outputc_o.valid), 64'(1));
      chk("pre_rst_lck", 64'(lck_o), 64'(4'b0001));
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_lck", 64'(lck_o), 64'(4'b0000));
      chk("mid_rst_rdy", 64'(rdy_o), 64'(4'b1111));
      chk("mid_rst_link", 64'(outputc_o), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick('0, "post_rst_idle");
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
